// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - program executor running wash/rinse/spin phase sequences on a 1 s tick
module wash_sequencer #(
  parameter logic [7:0] WASH_T  = 8'd9,
  parameter logic [7:0] RINSE_T = 8'd6,
  parameter logic [7:0] SPIN_T  = 8'd3,
  parameter logic [7:0] BUZZ_T  = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_led,
  input  logic       start_pause,
  input  logic       tick_1s,
  input  logic [2:0] model_now,
  output logic [2:0] cur_phase,
  output logic       running,
  output logic [7:0] remain_time,
  output logic       motor_on,
  output logic       water_in,
  output logic       drain,
  output logic       buzzer,
  output logic       if_finish
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    DONE  = 3'd4
  } phase_e;

  // Phase membership per program as {wash, rinse, spin}; codes 6/7 fall back to program 0.
  function automatic logic [2:0] prog_mask(input logic [2:0] code);
    case (code)
      3'd1:    prog_mask = 3'b100;
      3'd2:    prog_mask = 3'b110;
      3'd3:    prog_mask = 3'b010;
      3'd4:    prog_mask = 3'b011;
      3'd5:    prog_mask = 3'b001;
      default: prog_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] prog_total(input logic [2:0] mask);
    logic [7:0] t;
    t = 8'd0;
    if (mask[2]) t = t + WASH_T;
    if (mask[1]) t = t + RINSE_T;
    if (mask[0]) t = t + SPIN_T;
    return t;
  endfunction

  // First listed phase strictly after cur; from IDLE this is the program's first phase.
  function automatic phase_e next_phase(input logic [2:0] mask, input phase_e cur);
    phase_e n;
    n = DONE;
    case (cur)
      IDLE: begin
        if (mask[2])      n = WASH;
        else if (mask[1]) n = RINSE;
        else if (mask[0]) n = SPIN;
      end
      WASH: begin
        if (mask[1])      n = RINSE;
        else if (mask[0]) n = SPIN;
      end
      RINSE: begin
        if (mask[0])      n = SPIN;
      end
      default: n = DONE;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] phase_dur(input phase_e p);
    case (p)
      WASH:    phase_dur = WASH_T;
      RINSE:   phase_dur = RINSE_T;
      SPIN:    phase_dur = SPIN_T;
      default: phase_dur = 8'd0;
    endcase
  endfunction

  phase_e     phase_q, phase_d;
  logic       running_q, running_d;
  logic [7:0] remain_q, remain_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] buzz_q, buzz_d;
  logic [2:0] prog_q, prog_d;
  logic       finish_q, finish_d;
  logic       motor_q, motor_d;
  logic       water_q, water_d;
  logic       drain_q, drain_d;
  logic       buzzer_q, buzzer_d;
  logic       tick_ok;

  // A tick only counts while running and not coincident with a start/pause toggle.
  assign tick_ok = running_q && !start_pause && tick_1s;

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= IDLE;
      running_q <= 1'b0;
      remain_q  <= 8'd0;
      cnt_q     <= 8'd0;
      buzz_q    <= 8'd0;
      prog_q    <= 3'd0;
      finish_q  <= 1'b0;
      motor_q   <= 1'b0;
      water_q   <= 1'b0;
      drain_q   <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      running_q <= running_d;
      remain_q  <= remain_d;
      cnt_q     <= cnt_d;
      buzz_q    <= buzz_d;
      prog_q    <= prog_d;
      finish_q  <= finish_d;
      motor_q   <= motor_d;
      water_q   <= water_d;
      drain_q   <= drain_d;
      buzzer_q  <= buzzer_d;
    end
  end

  // Next-state logic; enables are decoded from the next state so every output is registered.
  always_comb begin
    phase_d   = phase_q;
    running_d = running_q;
    remain_d  = remain_q;
    cnt_d     = cnt_q;
    buzz_d    = buzz_q;
    prog_d    = prog_q;
    finish_d  = finish_q;

    if (!power_led) begin
      phase_d   = IDLE;
      running_d = 1'b0;
      remain_d  = 8'd0;
      cnt_d     = 8'd0;
      buzz_d    = 8'd0;
      prog_d    = 3'd0;
      finish_d  = 1'b0;
    end else begin
      case (phase_q)
        IDLE: begin
          running_d = 1'b0;
          finish_d  = 1'b0;
          buzz_d    = 8'd0;
          remain_d  = prog_total(prog_mask(model_now));
          if (start_pause) begin
            prog_d    = (model_now > 3'd5) ? 3'd0 : model_now;
            phase_d   = next_phase(prog_mask(model_now), IDLE);
            cnt_d     = phase_dur(phase_d);
            running_d = 1'b1;
          end
        end
        WASH, RINSE, SPIN: begin
          if (start_pause) running_d = !running_q;
          if (tick_ok) begin
            if (remain_q != 8'd0) remain_d = remain_q - 8'd1;
            if (cnt_q <= 8'd1) begin
              phase_d = next_phase(prog_mask(prog_q), phase_q);
              if (phase_d == DONE) begin
                running_d = 1'b0;
                cnt_d     = 8'd0;
                remain_d  = 8'd0;
                buzz_d    = BUZZ_T;
                finish_d  = 1'b1;
              end else begin
                cnt_d = phase_dur(phase_d);
              end
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        DONE: begin
          running_d = 1'b0;
          remain_d  = 8'd0;
          finish_d  = 1'b1;
          if (start_pause) begin
            phase_d  = IDLE;
            finish_d = 1'b0;
            buzz_d   = 8'd0;
          end else if (tick_1s && buzz_q != 8'd0) begin
            buzz_d = buzz_q - 8'd1;
          end
        end
        default: begin
          phase_d   = IDLE;
          running_d = 1'b0;
        end
      endcase
    end

    motor_d  = running_d && (phase_d == WASH || phase_d == RINSE || phase_d == SPIN);
    water_d  = running_d && (phase_d == WASH || phase_d == RINSE);
    drain_d  = running_d && (phase_d == SPIN);
    buzzer_d = (phase_d == DONE) && (buzz_d != 8'd0);
  end

  assign cur_phase   = phase_q;
  assign running     = running_q;
  assign remain_time = remain_q;
  assign motor_on    = motor_q;
  assign water_in    = water_q;
  assign drain       = drain_q;
  assign buzzer      = buzzer_q;
  assign if_finish   = finish_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed scoreboard bench for wash_sequencer
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_led;
  logic       start_pause;
  logic       tick_1s;
  logic [2:0] model_now;
  logic [2:0] cur_phase;
  logic       running;
  logic [7:0] remain_time;
  logic       motor_on;
  logic       water_in;
  logic       drain;
  logic       buzzer;
  logic       if_finish;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wash_sequencer #(
    .WASH_T (8'd3),
    .RINSE_T(8'd2),
    .SPIN_T (8'd1),
    .BUZZ_T (8'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .power_led  (power_led),
    .start_pause(start_pause),
    .tick_1s    (tick_1s),
    .model_now  (model_now),
    .cur_phase  (cur_phase),
    .running    (running),
    .remain_time(remain_time),
    .motor_on   (motor_on),
    .water_in   (water_in),
    .drain      (drain),
    .buzzer     (buzzer),
    .if_finish  (if_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // {phase, running, remain, motor, water, drain, buzzer, finish}
  function automatic logic [16:0] pk(input logic [2:0] ph, input logic run, input logic [7:0] rem,
                                     input logic m, input logic w, input logic d,
                                     input logic b, input logic f);
    return {ph, run, rem, m, w, d, b, f};
  endfunction

  task automatic push(input string tag, input logic [16:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_pop();
    exp_t        x;
    logic [16:0] obs;
    obs = {cur_phase, running, remain_time, motor_on, water_in, drain, buzzer, if_finish};
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow: got empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: got %05h expected %05h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag, input logic [16:0] e);
    push(tag, e);
    step();
    check_pop();
  endtask

  task automatic start_chk(input string tag, input logic [16:0] e);
    push(tag, e);
    start_pause = 1'b1;
    step();
    start_pause = 1'b0;
    check_pop();
  endtask

  task automatic tick_chk(input string tag, input logic [16:0] e);
    push(tag, e);
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    check_pop();
  endtask

  initial begin
    reset       = 1'b0;
    power_led   = 1'b0;
    start_pause = 1'b0;
    tick_1s     = 1'b0;
    model_now   = 3'd0;
    step();
    step();
    push("reset_state", pk(3'd0, 0, 8'd0, 0, 0, 0, 0, 0));
    check_pop();

    reset     = 1'b1;
    power_led = 1'b1;
    idle_chk("idle_total_p0", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));
    model_now = 3'd3;
    idle_chk("idle_total_p3", pk(3'd0, 0, 8'd2, 0, 0, 0, 0, 0));
    model_now = 3'd0;
    idle_chk("idle_total_p0b", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));

    // full program 0
    start_chk("p0_start", pk(3'd1, 1, 8'd6, 1, 1, 0, 0, 0));
    tick_chk("p0_t1", pk(3'd1, 1, 8'd5, 1, 1, 0, 0, 0));
    tick_chk("p0_t2", pk(3'd1, 1, 8'd4, 1, 1, 0, 0, 0));
    tick_chk("p0_t3", pk(3'd2, 1, 8'd3, 1, 1, 0, 0, 0));
    tick_chk("p0_t4", pk(3'd2, 1, 8'd2, 1, 1, 0, 0, 0));
    tick_chk("p0_t5", pk(3'd3, 1, 8'd1, 1, 0, 1, 0, 0));
    tick_chk("p0_t6_done", pk(3'd4, 0, 8'd0, 0, 0, 0, 1, 1));
    idle_chk("p0_done_hold", pk(3'd4, 0, 8'd0, 0, 0, 0, 1, 1));
    tick_chk("p0_buzz1", pk(3'd4, 0, 8'd0, 0, 0, 0, 1, 1));
    tick_chk("p0_buzz2", pk(3'd4, 0, 8'd0, 0, 0, 0, 0, 1));
    tick_chk("p0_buzz_floor", pk(3'd4, 0, 8'd0, 0, 0, 0, 0, 1));
    start_chk("p0_ack", pk(3'd0, 0, 8'd0, 0, 0, 0, 0, 0));
    idle_chk("p0_idle_again", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));

    // program 5 with model_now changed after the latch
    model_now = 3'd5;
    idle_chk("p5_idle", pk(3'd0, 0, 8'd1, 0, 0, 0, 0, 0));
    start_chk("p5_start", pk(3'd3, 1, 8'd1, 1, 0, 1, 0, 0));
    model_now = 3'd1;
    idle_chk("p5_model_ignored", pk(3'd3, 1, 8'd1, 1, 0, 1, 0, 0));
    tick_chk("p5_done", pk(3'd4, 0, 8'd0, 0, 0, 0, 1, 1));
    start_chk("p5_ack", pk(3'd0, 0, 8'd0, 0, 0, 0, 0, 0));
    model_now = 3'd0;
    idle_chk("p5_idle_after", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));

    // pause / resume, and pause coincident with a tick
    start_chk("pz_start", pk(3'd1, 1, 8'd6, 1, 1, 0, 0, 0));
    tick_chk("pz_t1", pk(3'd1, 1, 8'd5, 1, 1, 0, 0, 0));
    start_chk("pz_pause", pk(3'd1, 0, 8'd5, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      tick_chk("pz_paused_tick", pk(3'd1, 0, 8'd5, 0, 0, 0, 0, 0));
    end
    start_chk("pz_resume", pk(3'd1, 1, 8'd5, 1, 1, 0, 0, 0));
    tick_chk("pz_t2", pk(3'd1, 1, 8'd4, 1, 1, 0, 0, 0));
    push("pz_pause_with_tick", pk(3'd1, 0, 8'd4, 0, 0, 0, 0, 0));
    start_pause = 1'b1;
    tick_1s     = 1'b1;
    step();
    start_pause = 1'b0;
    tick_1s     = 1'b0;
    check_pop();
    start_chk("pz_resume2", pk(3'd1, 1, 8'd4, 1, 1, 0, 0, 0));
    tick_chk("pz_t3_rinse", pk(3'd2, 1, 8'd3, 1, 1, 0, 0, 0));

    // power loss mid-rinse: synchronous clear
    power_led = 1'b0;
    push("pw_before_edge", pk(3'd2, 1, 8'd3, 1, 1, 0, 0, 0));
    check_pop();
    idle_chk("pw_cleared", pk(3'd0, 0, 8'd0, 0, 0, 0, 0, 0));
    start_chk("pw_start_ignored", pk(3'd0, 0, 8'd0, 0, 0, 0, 0, 0));
    power_led = 1'b1;
    idle_chk("pw_restored", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));

    // code 7 behaves as program 0, then async reset mid-spin
    model_now = 3'd7;
    idle_chk("p7_idle", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));
    start_chk("p7_start", pk(3'd1, 1, 8'd6, 1, 1, 0, 0, 0));
    tick_chk("p7_t1", pk(3'd1, 1, 8'd5, 1, 1, 0, 0, 0));
    tick_chk("p7_t2", pk(3'd1, 1, 8'd4, 1, 1, 0, 0, 0));
    tick_chk("p7_t3", pk(3'd2, 1, 8'd3, 1, 1, 0, 0, 0));
    tick_chk("p7_t4", pk(3'd2, 1, 8'd2, 1, 1, 0, 0, 0));
    tick_chk("p7_t5_spin", pk(3'd3, 1, 8'd1, 1, 0, 1, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    push("async_reset", pk(3'd0, 0, 8'd0, 0, 0, 0, 0, 0));
    check_pop();
    @(negedge clk);
    reset = 1'b1;
    idle_chk("post_reset_idle", pk(3'd0, 0, 8'd6, 0, 0, 0, 0, 0));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drained: got %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
